// File: rtl/prod_accum.sv
// prod_accum -- accumulates bursts of unsigned 16-bit products into a
// saturating ACC_W-bit sum, then holds the completed result until the
// downstream consumer takes it.
//
// Parameters
//   ACC_W       accumulator width in bits (16..32)
//
// Ports
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   prod        unsigned 8x8 product from upstream multiplier
//   prod_valid  prod / prod_last valid this cycle
//   prod_last   final product of the burst
//   prod_ready  block accepts a product this cycle (IDLE/ACCUM)
//   acc_out     accumulated burst sum (saturating)
//   acc_cnt     products in the burst, saturating at 255
//   acc_ovf     sticky saturation flag for the burst
//   acc_valid   acc_out/acc_cnt/acc_ovf hold a completed result
//   acc_ready   downstream accepts the result this cycle
module prod_accum #(
  parameter int unsigned ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      prod,
  input  logic             prod_valid,
  input  logic             prod_last,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [7:0]       acc_cnt,
  output logic             acc_ovf,
  output logic             acc_valid,
  input  logic             acc_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic [7:0]       cnt_q,   cnt_d;
  logic             ovf_q,   ovf_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;

  logic             in_xfer;
  logic             out_xfer;
  logic [ACC_W:0]   sum;
  logic             sat;

  assign in_xfer  = prod_valid & ready_q;
  assign out_xfer = valid_q & acc_ready;

  // One extra bit catches the carry out of the accumulator.
  assign sum = {1'b0, acc_q} + (ACC_W+1)'(prod);
  assign sat = sum[ACC_W];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_xfer) begin
          acc_d   = ACC_W'(prod);
          cnt_d   = 8'd1;
          ovf_d   = 1'b0;
          state_d = prod_last ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_xfer) begin
          acc_d   = sat ? '1 : sum[ACC_W-1:0];
          ovf_d   = ovf_q | sat;
          cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          state_d = prod_last ? S_DONE : S_ACCUM;
        end
      end
      S_DONE: begin
        if (out_xfer) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are registered copies decoded from the next state,
    // so they change on the same edge as the state itself.
    ready_d = (state_d != S_DONE);
    valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign prod_ready = ready_q;
  assign acc_valid  = valid_q;
  assign acc_out    = acc_q;
  assign acc_cnt    = cnt_q;
  assign acc_ovf    = ovf_q;

endmodule
